axis_uart_rx: RTL and testbench

AXIS_UART_RX -- requirements
Module: axis_uart_rx

---
 rtl/axis_uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_axis_uart_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream master output and one-cycle error pulses.
// Define AXIS_UART_RX_PARITY_EN to build the optional parity bit check.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low synchronized level
// ST_START  | timing to the middle of the start bit, rejecting glitches
// ST_DATA   | sampling DATA_WIDTH bits, LSB first, one per bit period
// ST_PARITY | sampling the parity bit (parity builds only)
// ST_STOP   | sampling the stop bit, delivering or flagging the frame
// ST_WAIT   | after a framing error, waiting for the line to return high
module axis_uart_rx #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [1:0]               parity_i,
    input  logic                     uart_rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100,
        ST_WAIT   = 3'b101
    } state_t;

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(2);

    state_t                   state;
    state_t                   state_nxt;
    logic                     rx_meta;
    logic                     rx_sync;
    logic [DIVIDER_WIDTH-1:0] cnt;
    logic [DIVIDER_WIDTH-1:0] div_lat;
    logic [DIVIDER_WIDTH-1:0] div_eff;
    logic [IDX_W-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic                     tick;
    logic                     deliver;
    logic                     ferr_set;

    assign div_eff = (clk_divider_i < MIN_DIV) ? MIN_DIV : clk_divider_i;
    assign tick    = (cnt == '0);

`ifdef AXIS_UART_RX_PARITY_EN
    logic [1:0] par_lat;
    logic       par_bad;
    logic       par_exp;
    logic       parity_err_q;

    // Odd mode wins when both mode bits are set.
    assign par_exp      = par_lat[0] ? ~^shift_q : ^shift_q;
    assign parity_err_o = parity_err_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            par_lat      <= 2'b00;
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (state == ST_STOP) && tick && par_bad;
            if ((state == ST_IDLE) && !rx_sync) begin
                par_lat <= parity_i;
                par_bad <= 1'b0;
            end else if ((state == ST_PARITY) && tick) begin
                par_bad <= (rx_sync != par_exp);
            end
        end
    end
`else
    logic par_bad;
    logic unused_parity;

    assign par_bad       = 1'b0;
    assign unused_parity = ^parity_i;
    assign parity_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_sync) state_nxt = ST_START;
            end
            ST_START: begin
                if (tick) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick && (bit_idx == LAST_IDX)) begin
`ifdef AXIS_UART_RX_PARITY_EN
                    state_nxt = (par_lat != 2'b00) ? ST_PARITY : ST_STOP;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_sync) begin
                        deliver   = !par_bad;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rx_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            cnt             <= '0;
            div_lat         <= '0;
            bit_idx         <= '0;
            shift_q         <= '0;
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            frame_err_o     <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            rx_meta     <= uart_rx_i;
            rx_sync     <= rx_meta;
            frame_err_o <= ferr_set;
            overrun_o   <= 1'b0;

            // The divider is captured once per frame so mid-frame edits are ignored.
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        cnt     <= div_eff >> 1;
                        div_lat <= div_eff;
                        bit_idx <= '0;
                    end
                end
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    cnt <= tick ? (div_lat - 1'b1) : (cnt - 1'b1);
                end
                default: ;
            endcase

            if ((state == ST_DATA) && tick) begin
                shift_q <= {rx_sync, shift_q[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end

            if (m_axis_tvalid_o && m_axis_tready_i) m_axis_tvalid_o <= 1'b0;

            // A same-cycle handshake frees the slot, so only a stalled beat overruns.
            if (deliver) begin
                if (m_axis_tvalid_o && !m_axis_tready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    m_axis_tdata_o  <= shift_q;
                    m_axis_tvalid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Self-checking bench for axis_uart_rx: vector table, corner sequences and
// random frames judged by a line-level reference model.
module tb_axis_uart_rx;

`ifdef AXIS_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] clk_divider_i;
    logic [1:0]  parity_i;
    logic        uart_rx_i;
    logic [7:0]  m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_o;

    always #5 clk_i = ~clk_i;

    axis_uart_rx #(.DATA_WIDTH(8), .DIVIDER_WIDTH(32)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .clk_divider_i   (clk_divider_i),
        .parity_i        (parity_i),
        .uart_rx_i       (uart_rx_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .parity_err_o    (parity_err_o),
        .frame_err_o     (frame_err_o),
        .overrun_o       (overrun_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int         n_beats = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    logic [7:0] got [0:1023];

    // Outputs change on posedge; observe them half a cycle later.
    always @(negedge clk_i) begin
        if (m_axis_tvalid_o && m_axis_tready_i) begin
            if (n_beats < 1024) got[n_beats] = m_axis_tdata_o;
            n_beats++;
        end
        if (parity_err_o) n_perr++;
        if (frame_err_o)  n_ferr++;
        if (overrun_o)    n_ovr++;
    end

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       send_par;
        logic       par_bit;
        logic       stop;
        int         div;
        int         exp_beats;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic tx_bit(input logic b, input int div);
        uart_rx_i = b;
        tick(div);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic send_par, input logic pb,
                              input logic stop, input int div, input bit chg);
        tx_bit(1'b0, div);
        if (chg) begin
            clk_divider_i = 32'd5;
            parity_i      = 2'b01;
        end
        for (int i = 0; i < 8; i++) tx_bit(d[i], div);
        if (send_par) tx_bit(pb, div);
        tx_bit(stop, div);
        uart_rx_i = 1'b1;
    endtask

    // Parity bit that makes the total count of ones odd (odd mode) or even.
    function automatic logic ref_par_bit(input logic [7:0] d, input logic [1:0] mode);
        int ones;
        ones = $countones(d);
        if (mode[0]) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    initial begin
        int b0, p0, f0, o0;
        logic [7:0] d;

        vecs[0]  = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 16, 1, 8'hA5, 0, 0};
        vecs[1]  = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 16, 1, 8'h3C, 0, 0};
        vecs[2]  = '{8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 16, 0, 8'h00, int'(PAR_EN), int'(!PAR_EN)};
        vecs[3]  = '{8'h3C, 2'b10, 1'b1, 1'b0, 1'b1, 16, int'(PAR_EN), 8'h3C, 0, int'(!PAR_EN)};
        vecs[4]  = '{8'h3C, 2'b11, 1'b1, 1'b1, 1'b1, 16, 1, 8'h3C, 0, 0};
        vecs[5]  = '{8'h00, 2'b01, 1'b1, 1'b1, 1'b1, 12, 1, 8'h00, 0, 0};
        vecs[6]  = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 7,  1, 8'hFF, 0, 0};
        vecs[7]  = '{8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 4,  1, 8'h81, 0, 0};
        vecs[8]  = '{8'h7E, 2'b10, 1'b1, 1'b1, 1'b1, 16, int'(!PAR_EN), 8'h7E, int'(PAR_EN), 0};
        vecs[9]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 16, 0, 8'h00, 0, 1};
        vecs[10] = '{8'hC3, 2'b01, 1'b1, 1'b1, 1'b1, 10, 1, 8'hC3, 0, 0};

        rstn_i          = 1'b0;
        uart_rx_i       = 1'b1;
        m_axis_tready_i = 1'b1;
        clk_divider_i   = 32'd16;
        parity_i        = 2'b00;
        tick(3);
        check("reset_tvalid", m_axis_tvalid_o, 0);
        check("reset_tdata", m_axis_tdata_o, 0);
        check("reset_perr", parity_err_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_ovr", overrun_o, 0);
        rstn_i = 1'b1;
        tick(5);

        for (int v = 0; v < 11; v++) begin
            b0 = n_beats; p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
            clk_divider_i = 32'(vecs[v].div);
            parity_i      = vecs[v].par;
            send_frame(vecs[v].data, vecs[v].send_par, vecs[v].par_bit, vecs[v].stop,
                       vecs[v].div, 1'b0);
            tick(2 * vecs[v].div + 8);
            check($sformatf("vec%0d_beats", v), n_beats - b0, vecs[v].exp_beats);
            if (vecs[v].exp_beats > 0) check($sformatf("vec%0d_data", v), got[b0], vecs[v].exp_data);
            check($sformatf("vec%0d_perr", v), n_perr - p0, vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), n_ovr - o0, 0);
        end

        // Stop bit low followed by a long low line: one framing error only.
        clk_divider_i = 32'd16;
        parity_i      = 2'b00;
        b0 = n_beats; f0 = n_ferr;
        d = 8'h55;
        tx_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) tx_bit(d[i], 16);
        tx_bit(1'b0, 64);
        uart_rx_i = 1'b1;
        tick(20);
        check("ferr_hold_pulses", n_ferr - f0, 1);
        check("ferr_hold_beats", n_beats - b0, 0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        tick(40);
        check("after_ferr_beats", n_beats - b0, 1);
        check("after_ferr_data", got[b0], 8'h0F);

        // Short low glitch rejected without any output.
        b0 = n_beats; p0 = n_perr; f0 = n_ferr;
        uart_rx_i = 1'b0;
        tick(4);
        uart_rx_i = 1'b1;
        tick(60);
        check("glitch_beats", n_beats - b0, 0);
        check("glitch_errs", (n_ferr - f0) + (n_perr - p0), 0);

        // Configuration changed after the start bit must not disturb the frame.
        b0 = n_beats; p0 = n_perr; f0 = n_ferr;
        clk_divider_i = 32'd16;
        parity_i      = 2'b00;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        tick(40);
        check("cfgchg_beats", n_beats - b0, 1);
        check("cfgchg_data", got[b0], 8'h96);
        check("cfgchg_errs", (n_ferr - f0) + (n_perr - p0), 0);
        clk_divider_i = 32'd16;
        parity_i      = 2'b00;

        // Back-to-back frames into a stalled sink.
        m_axis_tready_i = 1'b0;
        b0 = n_beats; o0 = n_ovr;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        tick(40);
        check("ovr_tvalid", m_axis_tvalid_o, 1);
        check("ovr_tdata", m_axis_tdata_o, 8'h11);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_no_beat", n_beats - b0, 0);
        m_axis_tready_i = 1'b1;
        tick(3);
        check("ovr_release_beats", n_beats - b0, 1);
        check("ovr_release_data", got[b0], 8'h11);
        check("ovr_release_tvalid", m_axis_tvalid_o, 0);

        // Reset in the middle of data bit 3 with a pending beat held.
        m_axis_tready_i = 1'b0;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        tick(40);
        check("rst_pre_tvalid", m_axis_tvalid_o, 1);
        b0 = n_beats; p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
        d = 8'h81;
        tx_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) tx_bit(d[i], 16);
        uart_rx_i = d[3];
        tick(5);
        rstn_i    = 1'b0;
        uart_rx_i = 1'b1;
        tick(3);
        check("rst_mid_tvalid", m_axis_tvalid_o, 0);
        check("rst_mid_tdata", m_axis_tdata_o, 0);
        check("rst_mid_errs", int'(parity_err_o) + int'(frame_err_o) + int'(overrun_o), 0);
        rstn_i = 1'b1;
        m_axis_tready_i = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        tick(40);
        check("rst_after_beats", n_beats - b0, 1);
        check("rst_after_data", got[b0], 8'h81);
        check("rst_after_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);

        // Random frames against the line-level reference model.
        for (int r = 0; r < 24; r++) begin
            logic [1:0] mode;
            logic       good_par, stop, pb, seen_stop, par_ok;
            int         div, exp_beats, exp_perr, exp_ferr;
            d        = 8'($urandom);
            mode     = 2'($urandom_range(0, 3));
            div      = $urandom_range(4, 24);
            good_par = ($urandom_range(0, 3) != 0);
            stop     = (PAR_EN || mode == 2'b00) ? ($urandom_range(0, 5) != 0) : 1'b1;
            pb       = ref_par_bit(d, mode) ^ !good_par;
            // Without the parity stage the parity bit occupies the stop slot.
            seen_stop = (mode != 2'b00 && !PAR_EN) ? pb : stop;
            par_ok    = !(PAR_EN && mode != 2'b00) || good_par;
            exp_ferr  = seen_stop ? 0 : 1;
            exp_perr  = (PAR_EN && mode != 2'b00 && !good_par) ? 1 : 0;
            exp_beats = (seen_stop && par_ok) ? 1 : 0;

            b0 = n_beats; p0 = n_perr; f0 = n_ferr;
            clk_divider_i = 32'(div);
            parity_i      = mode;
            send_frame(d, mode != 2'b00, pb, stop, div, 1'b0);
            tick(2 * div + 8);
            check($sformatf("rnd%0d_beats", r), n_beats - b0, exp_beats);
            if (exp_beats > 0) check($sformatf("rnd%0d_data", r), got[b0], d);
            check($sformatf("rnd%0d_perr", r), n_perr - p0, exp_perr);
            check($sformatf("rnd%0d_ferr", r), n_ferr - f0, exp_ferr);
        end

        check("parity_err_total_zero_when_disabled", PAR_EN ? 0 : n_perr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
